// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP frame sender among N_CH packet sources.
// Optional per-phase handshake watchdog enabled by defining UDP_ARB_WDOG_EN.
module udp_tx_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned MAX_LEN     = 1472,
  parameter int unsigned MIN_GAP     = 12,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      i_req,
  input  logic [N_CH*16-1:0]   i_src_port,
  input  logic [N_CH*16-1:0]   i_dst_port,
  input  logic [N_CH*16-1:0]   i_len,
  input  logic [N_CH*8-1:0]    i_data,
  output logic [N_CH-1:0]      o_rd,
  output logic [N_CH-1:0]      o_grant,
  output logic [N_CH-1:0]      o_done,
  output logic                 o_drop,
  output logic                 o_wdog_err,
  output logic [15:0]          o_src_port,
  output logic [15:0]          o_dst_port,
  output logic [15:0]          o_data_len,
  output logic [7:0]           o_in_data,
  output logic                 o_enable,
  input  logic                 i_ready,
  input  logic                 i_rd
);

  localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START, S_RELEASE, S_DONE, S_DROP, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_CH-1:0]    grant_q, grant_d;
  logic [N_CH-1:0]    done_q, done_d;
  logic               drop_q, drop_d;
  logic               enable_q, enable_d;
  logic [15:0]        src_q, dst_q, len_q;
  logic [IDX_W:0]     pick;

  logic [15:0] src_a [N_CH];
  logic [15:0] dst_a [N_CH];
  logic [15:0] len_a [N_CH];
  logic [7:0]  dat_a [N_CH];

  // Unpack the flat per-channel buses
  for (genvar k = 0; k < int'(N_CH); k++) begin : g_unpack
    assign src_a[k] = i_src_port[16*k +: 16];
    assign dst_a[k] = i_dst_port[16*k +: 16];
    assign len_a[k] = i_len[16*k +: 16];
    assign dat_a[k] = i_data[8*k +: 8];
  end

  // First requester at or after the start pointer; MSB flags a hit
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0] res;
    int unsigned    c;
    res = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      c = 32'(start) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!res[IDX_W] && req[IDX_W'(c)]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

`ifdef UDP_ARB_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_err_q, wdog_fire;
`else
  logic [31:0] unused_wdog_cfg;
  assign unused_wdog_cfg = WDOG_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    gap_d    = '0;
    pick     = rr_pick(i_req, ptr_q);
`ifdef UDP_ARB_WDOG_EN
    wdog_d    = '0;
    wdog_fire = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick[IDX_W] && i_ready) begin
          state_d = S_GRANT;
          idx_d   = pick[IDX_W-1:0];
          ptr_d   = (pick[IDX_W-1:0] == IDX_W'(N_CH - 1)) ? '0
                                                          : pick[IDX_W-1:0] + IDX_W'(1);
        end
      end
      S_GRANT: begin
        if (len_a[idx_q] == 16'd0 || len_a[idx_q] > 16'(MAX_LEN)) state_d = S_DROP;
        else state_d = S_START;
      end
      S_START: begin
        if (!i_ready) state_d = S_RELEASE;
`ifdef UDP_ARB_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          state_d   = S_DROP;
          wdog_fire = 1'b1;
        end
        else wdog_d = wdog_q + 1'b1;
`endif
      end
      S_RELEASE: begin
        if (i_ready) state_d = S_DONE;
`ifdef UDP_ARB_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          state_d   = S_DROP;
          wdog_fire = 1'b1;
        end
        else wdog_d = wdog_q + 1'b1;
`endif
      end
      S_DONE:  state_d = S_GAP;
      S_DROP:  state_d = S_GAP;
      S_GAP: begin
        if (gap_q == GAP_W'(MIN_GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    grant_d  = (state_d inside {S_GRANT, S_START, S_RELEASE, S_DONE, S_DROP})
               ? (N_CH'(1) << idx_d) : '0;
    done_d   = (state_d inside {S_DONE, S_DROP}) ? (N_CH'(1) << idx_d) : '0;
    drop_d   = (state_d == S_DROP);
    enable_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      gap_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      drop_q   <= 1'b0;
      enable_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      enable_q <= enable_d;
      // Sender fields captured once and held through its latch cycle
      if (state_q == S_GRANT) begin
        src_q <= src_a[idx_q];
        dst_q <= dst_a[idx_q];
        len_q <= len_a[idx_q];
      end
    end
  end

`ifdef UDP_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_fire;
    end
  end
  assign o_wdog_err = wdog_err_q;
`else
  assign o_wdog_err = 1'b0;
`endif

  assign o_grant    = grant_q;
  assign o_done     = done_q;
  assign o_drop     = drop_q;
  assign o_enable   = enable_q;
  assign o_src_port = src_q;
  assign o_dst_port = dst_q;
  assign o_data_len = len_q;
  assign o_in_data  = dat_a[idx_q];
  assign o_rd       = (i_rd && (state_q inside {S_START, S_RELEASE, S_DONE}))
                      ? (N_CH'(1) << idx_q) : '0;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter with a behavioural UDP sender.
// Watchdog scenario follows UDP_ARB_WDOG_EN.
module tb_udp_tx_arbiter;

  localparam int MIN_GAP = 12;
  localparam int WDOG    = 64;

  logic        clk, rst_n;
  logic [3:0]  i_req;
  logic [63:0] i_src_port, i_dst_port, i_len;
  logic [31:0] i_data;
  logic [3:0]  o_rd, o_grant, o_done;
  logic        o_drop, o_wdog_err, o_enable, i_ready, i_rd;
  logic [15:0] o_src_port, o_dst_port, o_data_len;
  logic [7:0]  o_in_data;
  logic [15:0] len_v [4];

  int checks, errors;

  assign i_src_port = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
  assign i_dst_port = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
  assign i_data     = {8'h13, 8'h12, 8'h11, 8'h10};
  assign i_len      = {len_v[3], len_v[2], len_v[1], len_v[0]};

  udp_tx_arbiter #(.N_CH(4), .IDX_W(2), .MAX_LEN(1472), .MIN_GAP(MIN_GAP),
                   .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_src_port(i_src_port),
    .i_dst_port(i_dst_port), .i_len(i_len), .i_data(i_data), .o_rd(o_rd),
    .o_grant(o_grant), .o_done(o_done), .o_drop(o_drop), .o_wdog_err(o_wdog_err),
    .o_src_port(o_src_port), .o_dst_port(o_dst_port), .o_data_len(o_data_len),
    .o_in_data(o_in_data), .o_enable(o_enable), .i_ready(i_ready), .i_rd(i_rd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sender model: 0 normal, 1 ready stuck high, 2 ready stuck low
  int          s_mode;
  logic        s_busy;
  logic [15:0] s_left;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_busy  = 1'b0;
      s_left  = '0;
      i_rd    = 1'b0;
      i_ready = (s_mode != 2);
    end else if (s_mode == 2) begin
      i_ready = 1'b0;
      i_rd    = 1'b0;
    end else if (s_mode == 1) begin
      i_ready = 1'b1;
      i_rd    = 1'b0;
    end else if (!s_busy) begin
      i_rd    = 1'b0;
      i_ready = 1'b1;
      if (o_enable) begin
        s_busy  = 1'b1;
        s_left  = o_data_len;
        i_ready = 1'b0;
      end
    end else if (s_left != 0) begin
      i_rd   = 1'b1;
      s_left = s_left - 16'd1;
    end else begin
      i_rd    = 1'b0;
      i_ready = 1'b1;
      s_busy  = 1'b0;
    end
  end

  // Observation log, sampled mid low phase
  int cyc, en_cycles, done_total, drop_cnt, wdog_cnt, last_done_cyc, grant_cyc, en_rise_cyc;
  int rd_cnt [4];
  int done_cnt [4];
  int glog [$];
  int ggap [$];
  logic last_drop, wdog_with_done, prev_en;
  logic [3:0] prev_grant;
  logic [7:0] last_rd_data;

  always @(negedge clk) begin
    int gch;
    #1;
    cyc = cyc + 1;
    if (o_enable) en_cycles = en_cycles + 1;
    for (int k = 0; k < 4; k++) begin
      if (o_rd[k]) rd_cnt[k] = rd_cnt[k] + 1;
      if (o_done[k]) begin
        done_cnt[k]   = done_cnt[k] + 1;
        done_total    = done_total + 1;
        last_done_cyc = cyc;
        last_drop     = o_drop;
        if (o_drop) drop_cnt = drop_cnt + 1;
      end
    end
    if (o_rd != 4'd0) last_rd_data = o_in_data;
    if (o_wdog_err) begin
      wdog_cnt       = wdog_cnt + 1;
      wdog_with_done = (o_done != 4'd0);
    end
    if (o_grant != 4'd0 && prev_grant == 4'd0) begin
      gch = -1;
      for (int k = 0; k < 4; k++) if (o_grant[k]) gch = k;
      glog.push_back(gch);
      ggap.push_back(cyc - last_done_cyc);
      grant_cyc = cyc;
    end
    if (o_enable && !prev_en) en_rise_cyc = cyc;
    prev_grant = o_grant;
    prev_en    = o_enable;
  end

  function automatic int gl(input int i);
    return (glog.size() > i) ? glog[i] : -1;
  endfunction

  function automatic int gg(input int i);
    return (ggap.size() > i) ? ggap[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    en_cycles = 0; done_total = 0; drop_cnt = 0; wdog_cnt = 0;
    last_done_cyc = 0; grant_cyc = 0; en_rise_cyc = 0;
    last_drop = 1'b0; wdog_with_done = 1'b0; last_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      rd_cnt[k]   = 0;
      done_cnt[k] = 0;
    end
    glog.delete();
    ggap.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 4'd0;
    repeat (3) tick();
    clear_logs();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Run until done_total reaches target; drop requests in clr_mask as they complete
  task automatic run_until(input int target, input logic [3:0] clr_mask, input int budget,
                           input string name);
    int n;
    n = 0;
    while (done_total < target && n < budget) begin
      tick();
      for (int k = 0; k < 4; k++) if (o_done[k] && clr_mask[k]) i_req[k] = 1'b0;
      n++;
    end
    checks++;
    if (done_total < target) begin
      errors++;
      $display("FAIL %s timeout done_total=%0d need=%0d", name, done_total, target);
    end
  endtask

  task automatic test_reset();
    s_mode = 2;
    rst_n  = 1'b0;
    i_req  = 4'd0;
    repeat (2) tick();
    checks++;
    if ({o_grant, o_done, o_rd, o_drop, o_wdog_err, o_enable} !== 15'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%h want=0", {o_grant, o_done, o_rd, o_drop, o_wdog_err, o_enable});
    end
    checks++;
    if ({o_src_port, o_dst_port, o_data_len} !== 48'd0) begin
      errors++;
      $display("FAIL reset_fields got=%h want=0", {o_src_port, o_dst_port, o_data_len});
    end
    clear_logs();
    rst_n = 1'b1;
    i_req = 4'b1111;
    repeat (20) tick();
    checks++;
    if (glog.size() != 0) begin
      errors++;
      $display("FAIL ready_low_hold grants=%0d want=0", glog.size());
    end
    s_mode = 0;
    run_until(1, 4'b1111, 300, "reset_first");
    checks++;
    if (gl(0) != 0) begin
      errors++;
      $display("FAIL reset_first_grant got=%0d want=0", gl(0));
    end
    i_req = 4'd0;
  endtask

  task automatic test_single();
    int req_cyc;
    do_reset();
    i_req   = 4'b0010;
    req_cyc = cyc;
    run_until(1, 4'b1111, 300, "single");
    checks++;
    if (gl(0) != 1 || glog.size() != 1) begin
      errors++;
      $display("FAIL single_grant got=%0d n=%0d want=1 n=1", gl(0), glog.size());
    end
    checks++;
    if (en_rise_cyc - req_cyc != 2 || en_rise_cyc - grant_cyc != 1) begin
      errors++;
      $display("FAIL single_latency req_to_en=%0d grant_to_en=%0d want=2,1",
               en_rise_cyc - req_cyc, en_rise_cyc - grant_cyc);
    end
    checks++;
    if (rd_cnt[1] != 16 || rd_cnt[0] + rd_cnt[2] + rd_cnt[3] != 0) begin
      errors++;
      $display("FAIL single_rd ch1=%0d others=%0d want=16,0", rd_cnt[1],
               rd_cnt[0] + rd_cnt[2] + rd_cnt[3]);
    end
    checks++;
    if (last_drop !== 1'b0 || done_cnt[1] != 1 || en_cycles != 1) begin
      errors++;
      $display("FAIL single_done drop=%b done1=%0d en_cyc=%0d want=0,1,1",
               last_drop, done_cnt[1], en_cycles);
    end
    checks++;
    if (o_src_port !== 16'h1001 || o_dst_port !== 16'h2001 || o_data_len !== 16'd16
        || last_rd_data !== 8'h11) begin
      errors++;
      $display("FAIL single_fields src=%h dst=%h len=%0d data=%h want=1001,2001,16,11",
               o_src_port, o_dst_port, o_data_len, last_rd_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) len_v[k] = 16'd8;
    i_req = 4'b1111;
    run_until(4, 4'b1111, 600, "rr");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gl(i) != i || rd_cnt[i] != 8) begin
        errors++;
        $display("FAIL rr_order slot=%0d got=%0d rd=%0d want=%0d rd=8", i, gl(i), rd_cnt[i], i);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gg(i) != MIN_GAP + 2) begin
        errors++;
        $display("FAIL rr_gap slot=%0d done_to_grant=%0d want=%0d", i, gg(i), MIN_GAP + 2);
      end
    end
  endtask

  task automatic test_drop();
    logic [15:0] lens [4];
    logic        exp_drop [4];
    lens[0] = 16'd0;    exp_drop[0] = 1'b1;
    lens[1] = 16'd1500; exp_drop[1] = 1'b1;
    lens[2] = 16'd1473; exp_drop[2] = 1'b1;
    lens[3] = 16'd1472; exp_drop[3] = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        checks++;
        if (en_cycles != 0 || rd_cnt[2] != 0) begin
          errors++;
          $display("FAIL drop_no_enable en_cyc=%0d rd=%0d want=0,0", en_cycles, rd_cnt[2]);
        end
      end
      len_v[2] = lens[i];
      i_req    = 4'b0100;
      run_until(i + 1, 4'b1111, 1700, "drop");
      checks++;
      if (last_drop !== exp_drop[i] || done_cnt[2] != i + 1) begin
        errors++;
        $display("FAIL drop_len len=%0d drop=%b done2=%0d want=%b,%0d",
                 lens[i], last_drop, done_cnt[2], exp_drop[i], i + 1);
      end
    end
    checks++;
    if (rd_cnt[2] != 1472) begin
      errors++;
      $display("FAIL drop_maxlen_rd got=%0d want=1472", rd_cnt[2]);
    end
  endtask

  task automatic test_no_starvation();
    do_reset();
    for (int k = 0; k < 4; k++) len_v[k] = 16'd4;
    i_req = 4'b0001;
    run_until(1, 4'b0000, 300, "starve_a");
    i_req[3] = 1'b1;
    run_until(2, 4'b1000, 300, "starve_b");
    run_until(3, 4'b1111, 300, "starve_c");
    checks++;
    if (gl(0) != 0 || gl(1) != 3 || gl(2) != 0) begin
      errors++;
      $display("FAIL starve_order got=%0d,%0d,%0d want=0,3,0", gl(0), gl(1), gl(2));
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    len_v[1] = 16'd10;
    s_mode   = 1;
    i_req    = 4'b0010;
`ifdef UDP_ARB_WDOG_EN
    run_until(1, 4'b1111, 400, "wdog");
    checks++;
    if (wdog_cnt != 1 || wdog_with_done !== 1'b1 || last_drop !== 1'b1) begin
      errors++;
      $display("FAIL wdog_pulse cnt=%0d with_done=%b drop=%b want=1,1,1",
               wdog_cnt, wdog_with_done, last_drop);
    end
    checks++;
    if (en_cycles != WDOG || rd_cnt[1] != 0) begin
      errors++;
      $display("FAIL wdog_enable en_cyc=%0d rd=%0d want=%0d,0", en_cycles, rd_cnt[1], WDOG);
    end
    s_mode = 0;
`else
    repeat (200) tick();
    checks++;
    if (done_total != 0 || o_enable !== 1'b1 || wdog_cnt != 0) begin
      errors++;
      $display("FAIL nowdog_wait done=%0d en=%b wdog=%0d want=0,1,0",
               done_total, o_enable, wdog_cnt);
    end
    s_mode = 0;
    run_until(1, 4'b1111, 300, "nowdog");
    checks++;
    if (last_drop !== 1'b0 || rd_cnt[1] != 10) begin
      errors++;
      $display("FAIL nowdog_done drop=%b rd=%0d want=0,10", last_drop, rd_cnt[1]);
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    int n;
    do_reset();
    len_v[0] = 16'd4;
    len_v[1] = 16'd32;
    i_req    = 4'b0010;
    n = 0;
    while (rd_cnt[1] < 3 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rd_cnt[1] < 3) begin
      errors++;
      $display("FAIL midrst_reach rd=%0d want>=3", rd_cnt[1]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_grant, o_done, o_rd, o_drop, o_wdog_err, o_enable, o_src_port, o_dst_port,
         o_data_len} !== 63'd0) begin
      errors++;
      $display("FAIL midrst_async grant=%b en=%b rd=%b len=%0d want=0",
               o_grant, o_enable, o_rd, o_data_len);
    end
    i_req = 4'b0011;
    repeat (2) tick();
    clear_logs();
    rst_n = 1'b1;
    run_until(1, 4'b0001, 300, "midrst_a");
    checks++;
    if (gl(0) != 0 || done_cnt[1] != 0 || done_cnt[0] != 1) begin
      errors++;
      $display("FAIL midrst_first grant=%0d done1=%0d done0=%0d want=0,0,1",
               gl(0), done_cnt[1], done_cnt[0]);
    end
    run_until(2, 4'b1111, 300, "midrst_b");
    checks++;
    if (gl(1) != 1 || rd_cnt[1] != 32) begin
      errors++;
      $display("FAIL midrst_second grant=%0d rd=%0d want=1,32", gl(1), rd_cnt[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    prev_en    = 1'b0;
    prev_grant = 4'd0;
    s_mode = 2;
    rst_n  = 1'b0;
    i_req  = 4'd0;
    for (int k = 0; k < 4; k++) len_v[k] = 16'd16;
    clear_logs();
    test_reset();
    for (int k = 0; k < 4; k++) len_v[k] = 16'd16;
    test_single();
    test_round_robin();
    test_drop();
    test_no_starvation();
    test_watchdog();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
